pipe_hazard_ctrl: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 27 ++
 rtl/hazard_match.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2,
        STEP  = 2'd3
    } ctrl_state_t;

    localparam logic [1:0]  FWD_RF    = 2'b00;
    localparam logic [1:0]  FWD_EXMEM = 2'b10;
    localparam logic [1:0]  FWD_MEMWB = 2'b01;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    // Longest RAW stall without forwarding: producer in EX, MEM, then WB.
    localparam logic [1:0]  STALL_MAX = 2'd3;

    // x0 is hard-wired to zero, so a write to it never produces a dependency.
    function automatic logic src_match(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] rd,
                                       input logic       regwr);
        return use_src && regwr && (rd == src) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - per-source register match flags against ID/EX, EX/MEM and MEM/WB
// Inputs : ID sources and use bits, destination/write-enable of each later stage.
// Outputs: <stage>_match_a (rs1) and <stage>_match_b (rs2) for ex, mem, wb.
module hazard_match
    import riscv_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwr,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwr,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwr,
    output logic       ex_match_a,
    output logic       ex_match_b,
    output logic       mem_match_a,
    output logic       mem_match_b,
    output logic       wb_match_a,
    output logic       wb_match_b
);

    assign ex_match_a  = src_match(id_use_rs1, id_rs1, ex_rd,  ex_regwr);
    assign ex_match_b  = src_match(id_use_rs2, id_rs2, ex_rd,  ex_regwr);
    assign mem_match_a = src_match(id_use_rs1, id_rs1, mem_rd, mem_regwr);
    assign mem_match_b = src_match(id_use_rs2, id_rs2, mem_rd, mem_regwr);
    assign wb_match_a  = src_match(id_use_rs1, id_rs1, wb_rd,  wb_regwr);
    assign wb_match_b  = src_match(id_use_rs2, id_rs2, wb_rd,  wb_regwr);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/forward sequencer with debug halt/step
// Inputs : clk, rst (sync, active-high), ID sources, stage rd/regwr, ex_memrd,
//          br_taken, halt_req (level), step (pulse).
// Outputs: pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
//          fwd_a, fwd_b, halted, stall_cnt, flush_cnt.
module pipe_hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwr,
    input  logic             ex_memrd,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwr,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwr,
    input  logic             br_taken,
    input  logic             halt_req,
    input  logic             step,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             pipe_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic ex_match_a, ex_match_b, mem_match_a, mem_match_b, wb_match_a, wb_match_b;

    hazard_match u_match (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_regwr    (ex_regwr),
        .mem_rd      (mem_rd),
        .mem_regwr   (mem_regwr),
        .wb_rd       (wb_rd),
        .wb_regwr    (wb_regwr),
        .ex_match_a  (ex_match_a),
        .ex_match_b  (ex_match_b),
        .mem_match_a (mem_match_a),
        .mem_match_b (mem_match_b),
        .wb_match_a  (wb_match_a),
        .wb_match_b  (wb_match_b)
    );

    ctrl_state_t      state_q, state_d, ret_state;
    logic [1:0]       stall_len_q, stall_len_d;
    logic             from_step_q, from_step_d;
    logic             post_rst_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             hazard, stall_active, flush_active;
    logic [1:0]       fwd_a_calc, fwd_b_calc;

    // With forwarding only a load in EX cannot be bypassed in time. Without
    // it every in-flight producer blocks, except one already in WB when the
    // register file passes its write straight through to the read port.
    always_comb begin
        if (FWD_EN) begin
            hazard = (ex_match_a || ex_match_b) && ex_memrd;
        end else begin
            hazard = ex_match_a || ex_match_b || mem_match_a || mem_match_b ||
                     (!RF_BYPASS && (wb_match_a || wb_match_b));
        end
    end

    // The younger producer (EX/MEM) holds the newest value, so it wins.
    always_comb begin
        fwd_a_calc = FWD_RF;
        fwd_b_calc = FWD_RF;
        if (FWD_EN) begin
            if (mem_match_a)                   fwd_a_calc = FWD_EXMEM;
            else if (wb_match_a && !RF_BYPASS) fwd_a_calc = FWD_MEMWB;
            if (mem_match_b)                   fwd_b_calc = FWD_EXMEM;
            else if (wb_match_b && !RF_BYPASS) fwd_b_calc = FWD_MEMWB;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_len_d  = stall_len_q;
        from_step_d  = from_step_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        pipe_en      = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        fwd_a        = fwd_a_calc;
        fwd_b        = fwd_b_calc;
        halted       = 1'b0;
        stall_active = 1'b0;
        flush_active = 1'b0;
        // A stall entered from a single step goes back to the debugger.
        ret_state    = (from_step_q && halt_req) ? HALT : RUN;

        if (rst || post_rst_q) begin
            // Hold the pipe in bubbles for one extra cycle so every register
            // is cleared to a NOP before the first fetch.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            fwd_a        = FWD_RF;
            fwd_b        = FWD_RF;
        end else if (state_q == HALT) begin
            halted = 1'b1;
            if (step)           state_d = STEP;
            else if (!halt_req) state_d = RUN;
        end else begin
            if (br_taken) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                pipe_en      = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                flush_active = 1'b1;
            end else if (hazard) begin
                pipe_en      = 1'b1;
                id_ex_flush  = 1'b1;
                stall_active = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                pipe_en  = 1'b1;
            end

            case (state_q)
                RUN: begin
                    if (!br_taken && hazard) begin
                        state_d     = STALL;
                        stall_len_d = 2'd1;
                        from_step_d = 1'b0;
                    end else if (!br_taken && halt_req) begin
                        state_d = HALT;
                    end
                end
                STEP: begin
                    if (!br_taken && hazard) begin
                        state_d     = STALL;
                        stall_len_d = 2'd1;
                        from_step_d = 1'b1;
                    end else begin
                        state_d = halt_req ? HALT : RUN;
                    end
                end
                STALL: begin
                    if (!br_taken && !FWD_EN && hazard && stall_len_q != STALL_MAX) begin
                        stall_len_d = stall_len_q + 2'd1;
                    end else begin
                        state_d = ret_state;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_len_q <= 2'd0;
            from_step_q <= 1'b0;
            post_rst_q  <= 1'b1;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_len_q <= stall_len_d;
            from_step_q <= from_step_d;
            post_rst_q  <= 1'b0;
            if (stall_active && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_active && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = rst ? '0 : stall_cnt_q;
    assign flush_cnt = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl in three configurations
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       use1, use2;
        logic [4:0] ex_rd;
        logic       ex_regwr, ex_memrd;
        logic [4:0] mem_rd;
        logic       mem_regwr;
        logic [4:0] wb_rd;
        logic       wb_regwr, br, halt_req, step;
    } in_t;

    typedef struct {
        int          g;
        logic [10:0] ctl;
        logic [31:0] sc, fc;
    } exp_t;

    localparam int M_RUN = 0, M_STALL = 1, M_HALT = 2, M_STEP = 3;

    typedef struct {
        int          mode;
        int          len;
        bit          from_step;
        bit          post;
        logic [31:0] sc, fc;
    } mst_t;

    logic        clk = 1'b0;
    in_t         vin;
    logic [10:0] ctl_o [3];
    logic [31:0] sc_o [3];
    logic [31:0] fc_o [3];
    exp_t        q [$];
    mst_t        ms [3];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    // g0: forwarding + RF bypass; g1: no forwarding, bypass, 3-bit counters;
    // g2: no forwarding, no bypass.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 1) ? 3 : 32;
        logic          pc_en, if_id_en, pipe_en, f1, f2, f3, halted;
        logic [1:0]    fa, fb;
        logic [CW-1:0] sc, fc;
        pipe_hazard_ctrl #(.FWD_EN(g == 0), .RF_BYPASS(g != 2), .CNT_W(CW)) u_dut (
            .clk(clk), .rst(vin.rst),
            .id_rs1(vin.rs1), .id_rs2(vin.rs2), .id_use_rs1(vin.use1), .id_use_rs2(vin.use2),
            .ex_rd(vin.ex_rd), .ex_regwr(vin.ex_regwr), .ex_memrd(vin.ex_memrd),
            .mem_rd(vin.mem_rd), .mem_regwr(vin.mem_regwr),
            .wb_rd(vin.wb_rd), .wb_regwr(vin.wb_regwr),
            .br_taken(vin.br), .halt_req(vin.halt_req), .step(vin.step),
            .pc_en(pc_en), .if_id_en(if_id_en), .pipe_en(pipe_en),
            .if_id_flush(f1), .id_ex_flush(f2), .ex_mem_flush(f3),
            .fwd_a(fa), .fwd_b(fb), .halted(halted),
            .stall_cnt(sc), .flush_cnt(fc)
        );
        assign ctl_o[g] = {pc_en, if_id_en, pipe_en, f1, f2, f3, fa, fb, halted};
        assign sc_o[g]  = 32'(sc);
        assign fc_o[g]  = 32'(fc);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit hit(logic u, logic [4:0] s, logic [4:0] r, logic w);
        return u && w && (r == s) && (r != 5'd0);
    endfunction

    function automatic logic [31:0] inc_sat(logic [31:0] v, logic [31:0] top);
        return (v == top) ? v : v + 32'd1;
    endfunction

    // Reference: what the pipeline should see this cycle, then where it goes next.
    function automatic exp_t model(int g);
        bit          fwd = (g == 0);
        bit          byp = (g != 2);
        logic [31:0] top = (g == 1) ? 32'd7 : 32'hFFFF_FFFF;
        bit          ea, eb, ma, mb, wa, wbm, haz, hreq;
        logic [1:0]  fa, fb;
        int          ret;
        exp_t        e;
        e.g  = g;
        e.sc = vin.rst ? 32'd0 : ms[g].sc;
        e.fc = vin.rst ? 32'd0 : ms[g].fc;
        if (vin.rst || ms[g].post) begin
            e.ctl = {3'b000, 3'b111, 2'b00, 2'b00, 1'b0};
            ms[g].post = vin.rst;
            if (vin.rst) ms[g] = '{M_RUN, 0, 1'b0, 1'b1, 32'd0, 32'd0};
            return e;
        end
        ea  = hit(vin.use1, vin.rs1, vin.ex_rd,  vin.ex_regwr);
        eb  = hit(vin.use2, vin.rs2, vin.ex_rd,  vin.ex_regwr);
        ma  = hit(vin.use1, vin.rs1, vin.mem_rd, vin.mem_regwr);
        mb  = hit(vin.use2, vin.rs2, vin.mem_rd, vin.mem_regwr);
        wa  = hit(vin.use1, vin.rs1, vin.wb_rd,  vin.wb_regwr);
        wbm = hit(vin.use2, vin.rs2, vin.wb_rd,  vin.wb_regwr);
        fa  = !fwd ? 2'b00 : ma ? 2'b10 : (wa && !byp)  ? 2'b01 : 2'b00;
        fb  = !fwd ? 2'b00 : mb ? 2'b10 : (wbm && !byp) ? 2'b01 : 2'b00;
        haz = fwd ? ((ea || eb) && vin.ex_memrd)
                  : (ea || eb || ma || mb || (!byp && (wa || wbm)));
        hreq = vin.halt_req;
        if (ms[g].mode == M_HALT) begin
            e.ctl = {6'b000000, fa, fb, 1'b1};
            if (vin.step)  ms[g].mode = M_STEP;
            else if (!hreq) ms[g].mode = M_RUN;
            return e;
        end
        if (vin.br) begin
            e.ctl = {6'b111111, fa, fb, 1'b0};
            ms[g].fc = inc_sat(ms[g].fc, top);
        end else if (haz) begin
            e.ctl = {6'b001010, fa, fb, 1'b0};
            ms[g].sc = inc_sat(ms[g].sc, top);
        end else begin
            e.ctl = {6'b111000, fa, fb, 1'b0};
        end
        ret = (ms[g].from_step && hreq) ? M_HALT : M_RUN;
        if (ms[g].mode == M_STALL) begin
            if (!vin.br && !fwd && haz && ms[g].len < 3) ms[g].len++;
            else ms[g].mode = ret;
        end else if (!vin.br && haz) begin
            ms[g].from_step = (ms[g].mode == M_STEP);
            ms[g].mode = M_STALL;
            ms[g].len = 1;
        end else if (ms[g].mode == M_STEP) begin
            ms[g].mode = hreq ? M_HALT : M_RUN;
        end else if (!vin.br && hreq) begin
            ms[g].mode = M_HALT;
        end
        return e;
    endfunction

    task automatic cycle();
        for (int g = 0; g < 3; g++) q.push_back(model(g));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vin = '0;
        vin.rst = 1'b1;
        cycle();
        vin.rst = 1'b0;
        cycle();
    endtask

    task automatic load_use();
        vin = '0;
        vin.rs1 = 5'd5; vin.use1 = 1'b1;
        vin.ex_rd = 5'd5; vin.ex_regwr = 1'b1; vin.ex_memrd = 1'b1;
        cycle();
    endtask

    // Monitor: every cycle the DUTs present a response for each pushed stimulus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("ctl_g%0d", e.g),   32'(ctl_o[e.g]), 32'(e.ctl));
                chk($sformatf("stall_g%0d", e.g), sc_o[e.g], e.sc);
                chk($sformatf("flush_g%0d", e.g), fc_o[e.g], e.fc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int g = 0; g < 3; g++) ms[g] = '{M_RUN, 0, 1'b0, 1'b0, 32'd0, 32'd0};
        vin = '0;
        @(posedge clk);
        #1;
        do_reset();

        // RAW producer x3 drains EX -> MEM -> WB with the consumer held in ID.
        vin = '0; vin.rs1 = 5'd3; vin.use1 = 1'b1; vin.ex_rd = 5'd3; vin.ex_regwr = 1'b1;
        cycle();
        vin.ex_regwr = 1'b0; vin.ex_rd = 5'd0; vin.mem_rd = 5'd3; vin.mem_regwr = 1'b1;
        cycle();
        vin.mem_regwr = 1'b0; vin.mem_rd = 5'd0; vin.wb_rd = 5'd3; vin.wb_regwr = 1'b1;
        cycle();
        vin = '0;
        cycle();
        chk("drain_stalls_fwd", sc_o[0], 32'd0);
        chk("drain_stalls_byp", sc_o[1], 32'd2);
        chk("drain_stalls_nobyp", sc_o[2], 32'd3);

        // Load-use, then the load reaches MEM and feeds rs1 from EX/MEM.
        load_use();
        vin = '0; vin.rs1 = 5'd5; vin.use1 = 1'b1; vin.mem_rd = 5'd5; vin.mem_regwr = 1'b1;
        cycle();
        chk("loaduse_stall_cnt", sc_o[0], 32'd1);

        // EX/MEM beats MEM/WB; x0 never matches.
        vin = '0; vin.rs2 = 5'd7; vin.use2 = 1'b1;
        vin.mem_rd = 5'd7; vin.mem_regwr = 1'b1; vin.wb_rd = 5'd7; vin.wb_regwr = 1'b1;
        cycle();
        vin.rs2 = 5'd0; vin.mem_rd = 5'd0; vin.wb_rd = 5'd0;
        cycle();

        // Branch resolved in the cycle after a load-use stall.
        load_use();
        vin = '0; vin.br = 1'b1;
        cycle();
        vin = '0;
        cycle();
        chk("branch_flush_cnt", fc_o[0], 32'd1);
        chk("branch_stall_cnt", sc_o[0], 32'd2);

        // Halt for a while, single-step once, then release.
        vin = '0; vin.halt_req = 1'b1;
        for (int i = 0; i < 11; i++) cycle();
        vin.step = 1'b1;
        cycle();
        vin.step = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        vin.halt_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Reset in the middle of a stall.
        load_use();
        do_reset();
        chk("rst_mid_stall_cnt", sc_o[0], 32'd0);

        // Randomised traffic with small register numbers to provoke matches.
        vin = '0;
        for (int n = 0; n < 3000; n++) begin
            vin.rst       = ($urandom_range(0, 399) == 0);
            vin.rs1       = 5'($urandom_range(0, 3));
            vin.rs2       = 5'($urandom_range(0, 3));
            vin.use1      = 1'($urandom);
            vin.use2      = 1'($urandom);
            vin.ex_rd     = 5'($urandom_range(0, 3));
            vin.ex_regwr  = 1'($urandom);
            vin.ex_memrd  = 1'($urandom);
            vin.mem_rd    = 5'($urandom_range(0, 3));
            vin.mem_regwr = 1'($urandom);
            vin.wb_rd     = 5'($urandom_range(0, 3));
            vin.wb_regwr  = 1'($urandom);
            vin.br        = ($urandom_range(0, 15) == 0);
            vin.step      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) vin.halt_req = ~vin.halt_req;
            cycle();
        end
        vin = '0;
        cycle();

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
